dpram_arbiter: RTL and testbench

DPRAM_ARBITER -- requirements
Module: dpram_arbiter

---
 rtl/dpram_arb_pkg.sv | 23 ++
 rtl/dpram_arb_rr.sv | 56 +++++
 rtl/dpram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dpram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_arb_pkg.sv
// -----------------------------------------------------------------------------
// dpram_arb_pkg
// Shared definitions for the two-requester dual-port-RAM arbiter:
//   - arb_state_t    : arbiter FSM encoding (IDLE=0, ACC=1, ACK=2)
//   - NUM_REQ        : number of requesters sharing the RAM port
//   - lock_cnt_width : width of the lock counter for a given MAX_LOCK
// -----------------------------------------------------------------------------
package dpram_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  // The lock counter only ever holds 0 .. MAX_LOCK-1.
  function automatic int lock_cnt_width(input int max_lock);
    return (max_lock > 2) ? $clog2(max_lock) : 1;
  endfunction

endpackage

// File: rtl/dpram_arb_rr.sv
// -----------------------------------------------------------------------------
// dpram_arb_rr
// Two-way round-robin picker with optional grant locking.
// Optional feature macro: DPRAM_ARB_LOCK_EN (lock re-grant of the last-served
// requester, bounded by MAX_LOCK consecutive grants).
//
// Ports:
//   i_req      [1:0]     request lines of requester 1/0
//   i_lock     [1:0]     lock requests of requester 1/0
//   i_lst                last-served requester
//   i_lock_cnt [LCW-1:0] consecutive locked re-grants already given
//   o_gnt                requester to grant (meaningful when any i_req is set)
//   o_lock_hit           grant came from the lock path (counter must advance)
// -----------------------------------------------------------------------------
module dpram_arb_rr
  import dpram_arb_pkg::*;
#(
  parameter int MAX_LOCK = 4,
  parameter int LCW      = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_lock,
  input  logic               i_lst,
  input  logic [LCW-1:0]     i_lock_cnt,
  output logic               o_gnt,
  output logic               o_lock_hit
);

  logic w_rr_gnt;
  logic w_hit;

  // Plain round robin: a tie goes to whoever was not served last.
  always_comb begin
    w_rr_gnt = 1'b0;
    if (i_req[0] && i_req[1]) begin
      w_rr_gnt = ~i_lst;
    end else if (i_req[1]) begin
      w_rr_gnt = 1'b1;
    end
  end

`ifdef DPRAM_ARB_LOCK_EN
  localparam logic [LCW-1:0] LOCK_LIM = LCW'(MAX_LOCK - 1);

  // Last-served requester keeps the port while it holds lock, up to the limit.
  assign w_hit = i_req[i_lst] & i_lock[i_lst] & (i_lock_cnt < LOCK_LIM);
`else
  logic w_unused;
  assign w_unused = ^{i_lock, i_lock_cnt};
  assign w_hit    = 1'b0;
`endif

  assign o_gnt      = w_hit ? i_lst : w_rr_gnt;
  assign o_lock_hit = w_hit;

endmodule

// File: rtl/dpram_arbiter.sv
// -----------------------------------------------------------------------------
// dpram_arbiter
// Arbitrates two Wishbone-style requesters onto one RAM port. Each access runs
// IDLE -> ACC (RAM address/write cycle) -> ACK (one-cycle ack, read data
// returned), giving one access per 3 cycles at best.
// Optional feature macro: DPRAM_ARB_LOCK_EN (back-to-back locked grants,
// at most MAX_LOCK in a row to one requester).
//
// Handshake: a requester raises reqN_i with weN_i/addrN_i/datN_i stable and
// holds them until ackN_o pulses for one cycle; datN_o carries the read word
// only in that cycle (zero otherwise). Requests are only sampled in IDLE, so a
// request that appears during ACC/ACK waits for the next IDLE cycle. Dropping a
// request after it was granted does not abort the access.
//
// Ports:
//   wb_clk_i, wb_rst_i                  clock, async active-high reset
//   req0_i/req1_i                       access requests
//   we0_i/we1_i [3:0]                   byte write enables (0 = read)
//   addr0_i/addr1_i [ADDR_WIDTH-1:0]    word addresses
//   dat0_i/dat1_i [31:0]                write data
//   lock0_i/lock1_i                     back-to-back grant requests
//   ack0_o/ack1_o                       access-complete pulses
//   dat0_o/dat1_o [31:0]                read data, valid with ack
//   ram_addr_o/ram_we_o/ram_di_o        RAM port drive (zero outside ACC)
//   ram_do_i [31:0]                     RAM read data, valid the cycle after ACC
//   dbg_state_o [1:0]                   current FSM state (debug)
// -----------------------------------------------------------------------------
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int MAX_LOCK   = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  req0_i,
  input  logic [3:0]            we0_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [31:0]           dat0_i,
  input  logic                  lock0_i,
  input  logic                  req1_i,
  input  logic [3:0]            we1_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [31:0]           dat1_i,
  input  logic                  lock1_i,
  output logic                  ack0_o,
  output logic [31:0]           dat0_o,
  output logic                  ack1_o,
  output logic [31:0]           dat1_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [3:0]            ram_we_o,
  output logic [31:0]           ram_di_o,
  input  logic [31:0]           ram_do_i,
  output logic [1:0]            dbg_state_o
);

  localparam int LCW = lock_cnt_width(MAX_LOCK);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_gnt;
  logic       r_lst;
  logic       w_any_req;
  logic       w_pick;
  logic       w_lock_hit;
  logic [LCW-1:0] w_lock_cnt;

  assign w_any_req = req0_i | req1_i;

  dpram_arb_rr #(
    .MAX_LOCK (MAX_LOCK),
    .LCW      (LCW)
  ) u_rr (
    .i_req      ({req1_i, req0_i}),
    .i_lock     ({lock1_i, lock0_i}),
    .i_lst      (r_lst),
    .i_lock_cnt (w_lock_cnt),
    .o_gnt      (w_pick),
    .o_lock_hit (w_lock_hit)
  );

  // FSM state register plus grant / last-served bookkeeping.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_gnt   <= 1'b0;
      r_lst   <= 1'b1;  // requester 0 wins the first tie
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_any_req) begin
        r_gnt <= w_pick;
      end
      if (r_state == ACK) begin
        r_lst <= r_gnt;
      end
    end
  end

`ifdef DPRAM_ARB_LOCK_EN
  logic [LCW-1:0] r_lock_cnt;

  // Counts locked re-grants; restarts whenever the port changes hands.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_lock_cnt <= '0;
    end else if (r_state == IDLE && w_any_req) begin
      if (w_lock_hit) begin
        r_lock_cnt <= r_lock_cnt + 1'b1;
      end else if (w_pick != r_lst) begin
        r_lock_cnt <= '0;
      end
    end
  end

  assign w_lock_cnt = r_lock_cnt;
`else
  logic w_unused;
  assign w_unused   = w_lock_hit;
  assign w_lock_cnt = '0;
`endif

  // Next-state logic: each access is a fixed IDLE -> ACC -> ACK walk.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = ACC;
      ACC:     w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // RAM port mux: only the granted requester drives the port, and only in ACC.
  // Being decoded from r_state, the write enable drops as soon as reset hits.
  always_comb begin
    ram_addr_o = '0;
    ram_we_o   = '0;
    ram_di_o   = '0;
    if (r_state == ACC) begin
      if (r_gnt) begin
        ram_addr_o = addr1_i;
        ram_we_o   = we1_i;
        ram_di_o   = dat1_i;
      end else begin
        ram_addr_o = addr0_i;
        ram_we_o   = we0_i;
        ram_di_o   = dat0_i;
      end
    end
  end

  // Ack/data return: RAM output registered its address at the end of ACC.
  assign ack0_o = (r_state == ACK) && !r_gnt;
  assign ack1_o = (r_state == ACK) &&  r_gnt;
  assign dat0_o = ack0_o ? ram_do_i : 32'd0;
  assign dat1_o = ack1_o ? ram_do_i : 32'd0;

  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_dpram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dpram_arbiter
// Bench for dpram_arbiter with a behavioural synchronous RAM on the shared
// port. Build with +define+DPRAM_ARB_LOCK_EN to exercise the lock feature.
// -----------------------------------------------------------------------------
module tb_dpram_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1, lock0, lock1;
  logic [3:0]  we0, we1;
  logic [2:0]  addr0, addr1;
  logic [31:0] dat0_i, dat1_i;
  logic        ack0, ack1;
  logic [31:0] dat0_o, dat1_o;
  logic [2:0]  ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_di, ram_do;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        id;
    logic [3:0]  we;
    logic [2:0]  addr;
    logic [31:0] wdat;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  dpram_arbiter #(.ADDR_WIDTH(3), .MAX_LOCK(4)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .req0_i      (req0),
    .we0_i       (we0),
    .addr0_i     (addr0),
    .dat0_i      (dat0_i),
    .lock0_i     (lock0),
    .req1_i      (req1),
    .we1_i       (we1),
    .addr1_i     (addr1),
    .dat1_i      (dat1_i),
    .lock1_i     (lock1),
    .ack0_o      (ack0),
    .dat0_o      (dat0_o),
    .ack1_o      (ack1),
    .dat1_o      (dat1_o),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_di_o    (ram_di),
    .ram_do_i    (ram_do),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- RAM model (registered read, byte writes) ----------------
  logic [31:0] mem [0:7];
  logic [31:0] r_rd;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= 32'd0;
      mem[0] <= 32'hCAFEF00D;
      mem[3] <= 32'hDEADBEEF;
      mem[5] <= 32'h11223344;
      r_rd   <= 32'd0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_di[8*b +: 8];
      r_rd <= mem[ram_addr];
    end
  end
  assign ram_do = r_rd;

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: no ack within cycle budget (t=%0t)", nm, $time);
  endtask

  task automatic set_req(input logic id, input logic v, input logic [3:0] we,
                         input logic [2:0] a, input logic [31:0] d);
    if (id) begin
      req1 = v; we1 = we; addr1 = a; dat1_i = d;
    end else begin
      req0 = v; we0 = we; addr0 = a; dat0_i = d;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(1'b0, 1'b0, 4'h0, 3'd0, 32'd0);
    set_req(1'b1, 1'b0, 4'h0, 3'd0, 32'd0);
    lock0 = 1'b0;
    lock1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",   32'({ack1, ack0}), 32'd0);
    chk("rst_we",    32'(ram_we), 32'd0);
    chk("rst_addr",  32'(ram_addr), 32'd0);
    chk("rst_dat",   dat0_o | dat1_o, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
  endtask

  // One isolated access from a table record. k counts negedges after driving:
  // k=1 IDLE (request seen), k=2 ACC, k=3 ACK, k=4 back in IDLE.
  task automatic run_vec(input vec_t v);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    set_req(v.id, 1'b1, v.we, v.addr, v.wdat);
    if (v.chk) exp_q.push_back(v.exp);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("idle_we",  32'(ram_we), 32'd0);
        chk("idle_ack", 32'({ack1, ack0}), 32'd0);
      end
      if (k == 2) begin
        chk("acc_addr", 32'(ram_addr), 32'(v.addr));
        chk("acc_we",   32'(ram_we), 32'(v.we));
        chk("acc_di",   ram_di, v.wdat);
      end
      if (!got && (ack0 || ack1)) begin
        got = 1'b1;
        chk("ack_lat", 32'(k), 32'd3);
        chk("ack_id", 32'({ack1, ack0}), v.id ? 32'd2 : 32'd1);
        if (v.chk && exp_q.size() > 0)
          chk("rd_data", v.id ? dat1_o : dat0_o, exp_q.pop_front());
        chk("other_dat", v.id ? dat0_o : dat1_o, 32'd0);
        set_req(v.id, 1'b0, 4'h0, 3'd0, 32'd0);
      end
      if (k == 4) chk("post_ack", 32'({ack1, ack0}), 32'd0);
    end
    if (!got) begin
      timeout_fail("vec_ack");
      set_req(v.id, 1'b0, 4'h0, 3'd0, 32'd0);
      exp_q.delete();
    end
  endtask

  // Both requesters hold requests; pattern bit i is the requester expected
  // for the i-th grant. Grants must be exactly 3 cycles apart.
  task automatic run_rr(input int n, input logic lk, input logic [15:0] pat);
    int cnt, cyc, last;
    do_reset();
    for (int i = 0; i < n; i++) exp_q.push_back(pat[i] ? 32'd2 : 32'd1);
    cnt = 0; cyc = 0; last = 0;
    @(posedge clk); #1;
    lock0 = lk;
    set_req(1'b0, 1'b1, 4'h0, 3'd3, 32'd0);
    set_req(1'b1, 1'b1, 4'h0, 3'd5, 32'd0);
    while (cnt < n && cyc < n * 3 + 12) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) begin
        chk("rr_gnt", 32'({ack1, ack0}), exp_q.pop_front());
        if (cnt > 0) chk("rr_gap", 32'(cyc - last), 32'd3);
        last = cyc;
        cnt++;
      end
    end
    if (cnt < n) timeout_fail("rr_ack");
    set_req(1'b0, 1'b0, 4'h0, 3'd0, 32'd0);
    set_req(1'b1, 1'b0, 4'h0, 3'd0, 32'd0);
    lock0 = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t v;
    bit got;

    //        id    we       addr  wdat           chk   exp
    vecs[0] = '{1'b0, 4'b0000, 3'd3, 32'h00000000, 1'b1, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 4'b0010, 3'd5, 32'h0000AB00, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 4'b0000, 3'd5, 32'h00000000, 1'b1, 32'h1122AB44};
    vecs[3] = '{1'b0, 4'b0101, 3'd2, 32'hAABBCCDD, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 4'b0000, 3'd2, 32'h00000000, 1'b1, 32'h00BB00DD};
    vecs[5] = '{1'b1, 4'b1111, 3'd7, 32'h12345678, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 4'b0000, 3'd7, 32'h00000000, 1'b1, 32'h12345678};
    vecs[7] = '{1'b1, 4'b0000, 3'd0, 32'h00000000, 1'b1, 32'hCAFEF00D};

    do_reset();
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Request dropped during ACC: write still lands and ack still pulses.
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 4'hF, 3'd1, 32'h0F0F0F0F);
    @(negedge clk);
    @(negedge clk);
    chk("drop_acc_we", 32'(ram_we), 32'hF);
    req0 = 1'b0;
    @(negedge clk);
    chk("drop_ack", 32'({ack1, ack0}), 32'd1);
    set_req(1'b0, 1'b0, 4'h0, 3'd0, 32'd0);
    v = '{1'b0, 4'b0000, 3'd1, 32'h0, 1'b1, 32'h0F0F0F0F};
    run_vec(v);

    // Request from 0 arriving in the ACK cycle of requester 1.
    @(posedge clk); #1;
    set_req(1'b1, 1'b1, 4'h0, 3'd0, 32'd0);
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (ack1) got = 1'b1;
    end
    if (!got) timeout_fail("late_ack1");
    set_req(1'b1, 1'b0, 4'h0, 3'd0, 32'd0);
    set_req(1'b0, 1'b1, 4'h0, 3'd3, 32'd0);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("late_idle_ack", 32'({ack1, ack0}), 32'd0);
    chk("late_idle_st",  32'(dbg_state), 32'd0);
    @(negedge clk);
    chk("late_acc_addr", 32'(ram_addr), 32'd3);
    @(negedge clk);
    chk("late_ack0", 32'({ack1, ack0}), 32'd1);
    chk("late_dat0", dat0_o, exp_q.pop_front());
    set_req(1'b0, 1'b0, 4'h0, 3'd0, 32'd0);
    repeat (2) @(negedge clk);

    // Round robin after reset, then with lock0 held.
    run_rr(4, 1'b0, 16'b1010);
`ifdef DPRAM_ARB_LOCK_EN
    run_rr(10, 1'b1, 16'b0000_0010_0001_0000);
`else
    run_rr(10, 1'b1, 16'b0000_0010_1010_1010);
`endif

    // Reset in ACC of a write.
    do_reset();
    @(posedge clk); #1;
    set_req(1'b1, 1'b1, 4'hF, 3'd6, 32'h55555555);
    @(negedge clk);
    @(negedge clk);
    chk("racc_we_pre", 32'(ram_we), 32'hF);
    #1 rst = 1'b1;
    #1;
    chk("racc_we",    32'(ram_we), 32'd0);
    chk("racc_state", 32'(dbg_state), 32'd0);
    chk("racc_ack",   32'({ack1, ack0}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("racc_noack", 32'({ack1, ack0}), 32'd0);
    set_req(1'b0, 1'b1, 4'h0, 3'd3, 32'd0);
    exp_q.push_back(32'd1);
    #1 rst = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        got = 1'b1;
        chk("racc_first_gnt", 32'({ack1, ack0}), exp_q.pop_front());
      end
    end
    if (!got) timeout_fail("racc_ack");
    set_req(1'b0, 1'b0, 4'h0, 3'd0, 32'd0);
    set_req(1'b1, 1'b0, 4'h0, 3'd0, 32'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

endmodule
